// File: rtl/item_hud_pkg.sv
// Shared definitions for the reward HUD overlay: colours, icon indices,
// timer width helper and the 1-bpp icon artwork used to populate the icon ROM.
package item_hud_pkg;

    localparam logic [11:0] C_BLACK  = 12'h000;
    localparam logic [11:0] C_BLUE   = 12'h00F;
    localparam logic [11:0] C_RED    = 12'hF00;
    localparam logic [11:0] C_YELLOW = 12'hFF0;

    typedef enum logic [1:0] {
        ICON_PROTECT = 2'd0,
        ICON_FROZEN  = 2'd1,
        ICON_FASTER  = 2'd2,
        ICON_LASER   = 2'd3
    } icon_e;

    // Bits needed to hold a countdown value in 0..bar_max.
    function automatic int tw_of(input int bar_max);
        return $clog2(bar_max + 1);
    endfunction

    // Icon artwork: shield outline, snowflake cross, speed stripes, laser beam.
    function automatic logic icon_bit(input logic [1:0] icon, input int r, input int c, input int size);
        logic on;
        on = 1'b0;
        case (icon)
            ICON_PROTECT: on = (r == 0) || (r == size - 1) || (c == 0) || (c == size - 1);
            ICON_FROZEN:  on = (r == c) || (r + c == size - 1);
            ICON_FASTER:  on = ((r / 4) % 2) == 0;
            ICON_LASER:   on = (c >= size / 2 - 2) && (c < size / 2 + 2);
            default:      on = 1'b0;
        endcase
        return on;
    endfunction

endpackage

// File: rtl/item_hud_overlay_if.sv
// Control and pixel bus of the reward HUD overlay.
// master = renderer/game logic side, slave = the overlay block.
interface item_hud_overlay_if #(
    parameter int N_ITEMS = 4
);
    logic               enable_reward;
    logic               tick_1s;
    logic [N_ITEMS-1:0] item_start;
    logic [N_ITEMS-1:0] item_clear;
    logic [10:0]        VGA_xpos;
    logic [10:0]        VGA_ypos;
    logic [11:0]        VGA_data;
    logic [N_ITEMS-1:0] item_active;
    logic [N_ITEMS-1:0] item_expired;

    modport master (
        output enable_reward, tick_1s, item_start, item_clear, VGA_xpos, VGA_ypos,
        input  VGA_data, item_active, item_expired
    );

    modport slave (
        input  enable_reward, tick_1s, item_start, item_clear, VGA_xpos, VGA_ypos,
        output VGA_data, item_active, item_expired
    );
endinterface

// File: rtl/item_icon_rom.sv
// Single-port 1-bit icon ROM, one ICON_SIZE x ICON_SIZE image per channel,
// one cycle read latency.
module item_icon_rom
    import item_hud_pkg::*;
#(
    parameter int N_ITEMS   = 4,
    parameter int ICON_SIZE = 24,
    parameter int AW        = $clog2(N_ITEMS * ICON_SIZE * ICON_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr_i,
    output logic          dout_o
);
    localparam int SQ    = ICON_SIZE * ICON_SIZE;
    localparam int DEPTH = N_ITEMS * SQ;

    logic rom_mem [DEPTH];
    logic dout_q;

    // Image index, row and column are all derived from the flat address.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        assign rom_mem[gi] = icon_bit(2'((gi / SQ) % 4), (gi % SQ) / ICON_SIZE, gi % ICON_SIZE, ICON_SIZE);
    end

    // Registered read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= 1'b0;
        end else begin
            dout_q <= rom_mem[addr_i];
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/item_hud_overlay.sv
// Multi-channel reward HUD overlay: per-channel countdown timers and a
// two-stage pixel pipeline drawing an icon plus remaining-time bar per row.
// Optional feature: define ITEM_HUD_BLINK_EN for low-time warning (red bar,
// blinking icon).
module item_hud_overlay
    import item_hud_pkg::*;
#(
    parameter int N_ITEMS   = 4,
    parameter int BAR_MAX   = 30,
    parameter int BAR_SCALE = 2,
    parameter int ICON_SIZE = 24,
    parameter int X0        = 490,
    parameter int Y0        = 48,
    parameter int ROW_PITCH = 28,
    parameter int BLINK_THR = 5
) (
    input  logic               clk,
    input  logic               rst,
    item_hud_overlay_if.slave  hud
);
    localparam int TW = tw_of(BAR_MAX);
    localparam int SQ = ICON_SIZE * ICON_SIZE;
    localparam int AW = $clog2(N_ITEMS * SQ);

    localparam logic [10:0] ICON_X_LO = 11'(X0);
    localparam logic [10:0] ICON_X_HI = 11'(X0 + ICON_SIZE);
    localparam logic [10:0] BAR_X_LO  = 11'(X0 + ICON_SIZE + 6);

    logic [TW-1:0]      cnt_w [N_ITEMS];
    logic [N_ITEMS-1:0] active_w;
    logic [N_ITEMS-1:0] expired_w;
    logic               tick_en;

    assign tick_en = hud.enable_reward & hud.tick_1s;

    // ------------------------------------------------------------------
    // Per-channel countdown timers
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N_ITEMS; gi++) begin : g_timer
        logic [TW-1:0] cnt_q, cnt_d;
        logic          act_q;
        logic          exp_q, exp_d;

        // Clear beats start, start beats an enabled tick; expiry only when counted down.
        always_comb begin
            cnt_d = cnt_q;
            exp_d = 1'b0;
            if (hud.item_clear[gi]) begin
                cnt_d = '0;
            end else if (hud.item_start[gi]) begin
                cnt_d = TW'(BAR_MAX);
            end else if (tick_en && (cnt_q != '0)) begin
                cnt_d = cnt_q - TW'(1);
                exp_d = (cnt_q == TW'(1));
            end
        end

        // Timer, active flag and expiry pulse registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
                act_q <= 1'b0;
                exp_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                act_q <= (cnt_d != '0);
                exp_q <= exp_d;
            end
        end

        assign cnt_w[gi]     = cnt_q;
        assign active_w[gi]  = act_q;
        assign expired_w[gi] = exp_q;
    end

    assign hud.item_active  = active_w;
    assign hud.item_expired = expired_w;

    // ------------------------------------------------------------------
    // Blink phase
    // ------------------------------------------------------------------
    logic phase_w;
`ifdef ITEM_HUD_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
    logic phase_q;

    // Phase flips once per enabled second.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= 1'b0;
        end else if (tick_en) begin
            phase_q <= ~phase_q;
        end
    end

    assign phase_w = phase_q;
`else
    localparam bit BLINK_ON = 1'b0;
    assign phase_w = 1'b0;
`endif

    // ------------------------------------------------------------------
    // S1: per-row hit decode
    // ------------------------------------------------------------------
    logic [N_ITEMS-1:0] icon_hit_w;
    logic [N_ITEMS-1:0] bar_hit_w;
    logic [N_ITEMS-1:0] warn_w;
    logic [AW-1:0]      addr_w [N_ITEMS];

    for (genvar gi = 0; gi < N_ITEMS; gi++) begin : g_row
        localparam int ROW_TOP = Y0 + gi * ROW_PITCH;
        logic [10:0] bar_len;
        logic        row_hit;

        assign bar_len = 11'(cnt_w[gi]) * 11'(BAR_SCALE);
        assign row_hit = (hud.VGA_ypos >= 11'(ROW_TOP)) && (hud.VGA_ypos < 11'(ROW_TOP + ICON_SIZE));

        assign icon_hit_w[gi] = row_hit && (hud.VGA_xpos >= ICON_X_LO) && (hud.VGA_xpos < ICON_X_HI);
        assign bar_hit_w[gi]  = (hud.VGA_ypos >= 11'(ROW_TOP + 7)) && (hud.VGA_ypos <= 11'(ROW_TOP + 17))
                              && (hud.VGA_xpos >= BAR_X_LO) && (hud.VGA_xpos < BAR_X_LO + bar_len);
        assign addr_w[gi]     = AW'(gi * SQ)
                              + AW'(hud.VGA_ypos - 11'(ROW_TOP)) * AW'(ICON_SIZE)
                              + AW'(hud.VGA_xpos - ICON_X_LO);
        assign warn_w[gi]     = BLINK_ON && (cnt_w[gi] != '0) && (cnt_w[gi] <= TW'(BLINK_THR));
    end

    logic [AW-1:0] rom_addr_d;
    logic          icon_d, bar_d, red_d;

    // Rows never overlap, so at most one row contributes to the current pixel.
    always_comb begin
        rom_addr_d = '0;
        icon_d     = 1'b0;
        bar_d      = 1'b0;
        red_d      = 1'b0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (icon_hit_w[i] && active_w[i]) begin
                rom_addr_d = addr_w[i];
                icon_d     = !(warn_w[i] && phase_w);
            end
            if (bar_hit_w[i]) begin
                bar_d = 1'b1;
                red_d = warn_w[i];
            end
        end
        if (!hud.enable_reward) begin
            icon_d = 1'b0;
            bar_d  = 1'b0;
            red_d  = 1'b0;
        end
    end

    logic rom_bit;

    item_icon_rom #(
        .N_ITEMS   (N_ITEMS),
        .ICON_SIZE (ICON_SIZE),
        .AW        (AW)
    ) u_icon_rom (
        .clk    (clk),
        .rst    (rst),
        .addr_i (rom_addr_d),
        .dout_o (rom_bit)
    );

    logic icon_q, bar_q, red_q;

    // S1 registers, aligned with the ROM's registered output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            icon_q <= 1'b0;
            bar_q  <= 1'b0;
            red_q  <= 1'b0;
        end else begin
            icon_q <= icon_d;
            bar_q  <= bar_d;
            red_q  <= red_d;
        end
    end

    // ------------------------------------------------------------------
    // S2: colour composition
    // ------------------------------------------------------------------
    logic [11:0] vga_q;

    // Final pixel colour; an icon hit with a clear ROM bit stays black.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_q <= C_BLACK;
        end else if (icon_q && rom_bit) begin
            vga_q <= C_YELLOW;
        end else if (bar_q) begin
            vga_q <= red_q ? C_RED : C_BLUE;
        end else begin
            vga_q <= C_BLACK;
        end
    end

    assign hud.VGA_data = vga_q;

endmodule

// File: tb/tb_item_hud_overlay.sv
// Self-checking bench for item_hud_overlay: directed scenarios plus
// randomized timer events and pixel scans against a behavioural model.
module tb_item_hud_overlay;
    import item_hud_pkg::*;

    localparam int N    = 4;
    localparam int BMAX = 30;
    localparam int X0   = 490;
    localparam int Y0   = 48;
    localparam int PIT  = 28;
    localparam int ISZ  = 24;
    localparam int THR  = 5;
`ifdef ITEM_HUD_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    item_hud_overlay_if #(.N_ITEMS(N)) hud ();

    item_hud_overlay #(.N_ITEMS(N)) dut (
        .clk (clk),
        .rst (rst),
        .hud (hud)
    );

    int n_vec = 0;
    int n_err = 0;

    int m_cnt [N];
    bit m_exp [N];
    bit m_phase;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Icon artwork as drawn: outline, X, 4-line stripes, 4-pixel vertical beam.
    function automatic bit art(input int i, input int r, input int c);
        case (i)
            0: return (r == 0) || (r == 23) || (c == 0) || (c == 23);
            1: return (r == c) || (r == 23 - c);
            2: return (r % 8) < 4;
            3: return (c >= 10) && (c <= 13);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [11:0] ref_px(input int x, input int y);
        bit warn;
        if (!hud.enable_reward) return 12'h000;
        for (int i = 0; i < N; i++) begin
            int top;
            top  = Y0 + i * PIT;
            warn = BLINK && (m_cnt[i] > 0) && (m_cnt[i] <= THR);
            if (y >= top && y < top + ISZ) begin
                if (x >= X0 && x < X0 + ISZ)
                    return (m_cnt[i] > 0 && art(i, y - top, x - X0) && !(warn && m_phase)) ? 12'hFF0 : 12'h000;
                if (y >= top + 7 && y <= top + 17 && x >= X0 + ISZ + 6 && x < X0 + ISZ + 6 + 2 * m_cnt[i])
                    return warn ? 12'hF00 : 12'h00F;
            end
        end
        return 12'h000;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_exp[i] = 1'b0;
        end
        m_phase = 1'b0;
    endfunction

    // One clock with the given pulses; checks active/expired after the edge.
    task automatic cyc(input bit tk, input logic [3:0] st, input logic [3:0] cl);
        logic [3:0] act, ex;
        hud.tick_1s    = tk;
        hud.item_start = st;
        hud.item_clear = cl;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            m_exp[i] = 1'b0;
            if (cl[i]) m_cnt[i] = 0;
            else if (st[i]) m_cnt[i] = BMAX;
            else if (hud.enable_reward && tk && m_cnt[i] > 0) begin
                m_exp[i] = (m_cnt[i] == 1);
                m_cnt[i] = m_cnt[i] - 1;
            end
        end
        if (hud.enable_reward && tk) m_phase = !m_phase;
        #1;
        hud.tick_1s    = 1'b0;
        hud.item_start = '0;
        hud.item_clear = '0;
        for (int i = 0; i < N; i++) begin
            act[i] = (m_cnt[i] != 0);
            ex[i]  = m_exp[i];
        end
        chk("active", 32'(hud.item_active), 32'(act));
        chk("expired", 32'(hud.item_expired), 32'(ex));
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1'b1, 4'b0000, 4'b0000);
    endtask

    // Stream x0..x1 along row y, one pixel per clock, checking 2-cycle latency.
    task automatic scan(input int y, input int x0, input int x1);
        logic [11:0] q[$];
        int          qx[$];
        int          px;
        hud.VGA_ypos = 11'(y);
        for (int x = x0; x <= x1 + 1; x++) begin
            hud.VGA_xpos = 11'(x);
            q.push_back(ref_px(x, y));
            qx.push_back(x);
            cyc(1'b0, 4'b0000, 4'b0000);
            if (q.size() >= 2) begin
                px = qx.pop_front();
                chk($sformatf("pixel(%0d,%0d)", px, y), 32'(hud.VGA_data), 32'(q.pop_front()));
            end
        end
    endtask

    initial begin
        rst               = 1'b1;
        hud.enable_reward = 1'b1;
        hud.tick_1s       = 1'b0;
        hud.item_start    = '0;
        hud.item_clear    = '0;
        hud.VGA_xpos      = '0;
        hud.VGA_ypos      = '0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_active", 32'(hud.item_active), 32'd0);
        chk("rst_expired", 32'(hud.item_expired), 32'd0);
        chk("rst_vga", 32'(hud.VGA_data), 32'd0);
        rst = 1'b0;

        // 1: start channel 1, three ticks -> 27, bar spans 54 pixels
        cyc(1'b0, 4'b0010, 4'b0000);
        ticks(3);
        chk("cnt1_is_27", 32'(m_cnt[1]), 32'd27);
        scan(Y0 + PIT + 10, X0 + 26, X0 + 90);
        scan(Y0 + PIT + 5, X0 - 2, X0 + ISZ + 1);

        // 2: countdown to zero with expiry pulse; clear at 5 gives no pulse
        cyc(1'b0, 4'b0001, 4'b0000);
        ticks(29);
        ticks(1);
        cyc(1'b0, 4'b0000, 4'b0000);
        cyc(1'b0, 4'b1000, 4'b0000);
        ticks(25);
        cyc(1'b0, 4'b0000, 4'b1000);
        scan(Y0 + 3 * PIT + 10, X0 - 4, X0 + 100);

        // 3: start+tick together restarts; clear+start together clears
        cyc(1'b0, 4'b0100, 4'b0000);
        ticks(20);
        cyc(1'b1, 4'b0100, 4'b0000);
        scan(Y0 + 2 * PIT + 12, X0 + 26, X0 + 95);
        cyc(1'b0, 4'b0100, 4'b0100);
        scan(Y0 + 2 * PIT + 12, X0 + 26, X0 + 40);

        // 4: disabled overlay freezes timers and draws black
        cyc(1'b0, 4'b1111, 4'b0000);
        ticks(2);
        hud.enable_reward = 1'b0;
        ticks(5);
        scan(Y0 + 10, X0 - 2, X0 + 95);
        scan(Y0 + PIT, X0 - 2, X0 + ISZ + 1);
        hud.enable_reward = 1'b1;
        ticks(1);
        scan(Y0 + 10, X0 + 26, X0 + 90);

        // 5: low-time warning colours and icon blink
        ticks(22);
        scan(Y0 + 10, X0 + 28, X0 + 45);
        scan(Y0, X0 - 1, X0 + ISZ);
        ticks(1);
        scan(Y0, X0 - 1, X0 + ISZ);
        ticks(1);
        scan(Y0 + 2, X0 - 1, X0 + ISZ);

        // Randomized events and scans
        for (int it = 0; it < 400; it++) begin
            logic [3:0] st, cl;
            hud.enable_reward = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < N; i++) begin
                st[i] = ($urandom_range(0, 15) == 0);
                cl[i] = ($urandom_range(0, 23) == 0);
            end
            cyc(($urandom_range(0, 2) == 0), st, cl);
            if ($urandom_range(0, 3) == 0) begin
                int ry, rx;
                ry = Y0 + $urandom_range(0, N * PIT - 1);
                rx = X0 - 6 + $urandom_range(0, 100);
                scan(ry, rx, rx + 12);
            end
        end
        hud.enable_reward = 1'b1;

        // 6: asynchronous reset mid-frame with all channels running
        cyc(1'b0, 4'b1111, 4'b0000);
        hud.VGA_xpos = 11'(X0 + ISZ + 10);
        hud.VGA_ypos = 11'(Y0 + 10);
        cyc(1'b0, 4'b0000, 4'b0000);
        cyc(1'b0, 4'b0000, 4'b0000);
        chk("pre_rst_vga", 32'(hud.VGA_data), 32'h00F);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_vga", 32'(hud.VGA_data), 32'd0);
        chk("async_rst_active", 32'(hud.item_active), 32'd0);
        chk("async_rst_expired", 32'(hud.item_expired), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        scan(Y0 + 10, X0 - 2, X0 + 70);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
